enc_arbiter: RTL and testbench
==============================

ENC_ARBITER -- requirements
Module: enc_arbiter

Interface
REQ-001 SHALL have parameter: IDLE_GAP, default 0, count of idle cycles (ser_out=0) forced between consecutive frames; legal range 0..15.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: req  input  4  request per requester i; held high until ack[i] seen.
REQ-005 SHALL have port: req_data  input  16  nibble of requester i in bits [4i+3:4i].
REQ-006 SHALL have port: ack  output  4  one-hot, one-cycle pulse: nibble of requester i captured.
REQ-007 SHALL have port: ser_out  output  1  serial Hamming(7,4) frame line; idle level 0.
REQ-008 SHALL have port: busy  output  1  high during every cycle a frame bit is driven.
REQ-009 SHALL have port: gnt_id  output  2  index of requester owning current/last frame.

Function
REQ-010 SHALL implement states IDLE, FRAME, GAP.
REQ-011 SHALL, in IDLE at a rising edge with any req bit high, grant round-robin: first requester after last granted index (wrapping 3->0) with req high.
REQ-012 SHALL, on grant edge, capture nibble d[3:0], set gnt_id, pulse ack[i], set busy, drive start bit 1 on ser_out, enter FRAME; all registered, visible the cycle after the edge.
REQ-013 SHALL drive frame bits one per cycle: start=1, d0, d1, d2, d3, p0=d0^d1^d2, p1=d0^d1^d3, p2=d0^d2^d3 (8 cycles, LSB data first).
REQ-014 SHALL, at the edge ending p2: if IDLE_GAP=0 and a req is pending, grant immediately (start bit in next cycle, no gap); if IDLE_GAP=0 and none pending, enter IDLE; if IDLE_GAP>0, enter GAP.
REQ-015 SHALL hold ser_out=0, busy=0 for exactly IDLE_GAP cycles in GAP, then evaluate requests as in IDLE.
REQ-016 SHALL ignore req and req_data changes during FRAME and GAP; nibble is frozen at grant.
REQ-017 SHALL sample req only at grant edges; a requester still asserting req at the next grant edge after its ack is treated as a new request.
REQ-018 SHALL drive ser_out=0, busy=0, ack=0 in IDLE; gnt_id holds last value.
REQ-019 SHALL assert at most one ack bit per cycle and exactly one ack per frame.

Reset
REQ-020 SHALL, on rst_n=0 at a rising edge, set ser_out=0, busy=0, ack=0, gnt_id=0, state IDLE, last-granted pointer=3 (requester 0 highest priority next).
REQ-021 SHALL abort any in-progress frame on reset; no partial frame resumes and no ack is reissued after reset.

Configuration
REQ-022 SHALL, with macro ENC_ARB_ID_EN defined, insert gnt_id[0] then gnt_id[1] between start bit and d0 (10-bit frame, busy high 10 cycles).
REQ-023 SHALL, without ENC_ARB_ID_EN, emit the 8-bit frame of REQ-013 only; all other behaviour identical.

Verification
REQ-024 SHALL cover: reset, req=0001, req_data[3:0]=1011 -> ack=0001 one cycle, ser_out 1,1,1,0,1,0,1,0, busy high 8 cycles, then ser_out=0.
REQ-025 SHALL cover: req=1111 held, all nibbles 0000, IDLE_GAP=0 -> grants 0,1,2,3,0 back-to-back, each frame 1,0,0,0,0,0,0,0, no idle cycle between frames.
REQ-026 SHALL cover: IDLE_GAP=3, req=0011 held -> frames for 0 then 1 separated by exactly 3 cycles of ser_out=0, busy=0.
REQ-027 SHALL cover: grant requester 2 with 0110, change req_data[11:8] to 1111 mid-frame -> frame remains 1,0,1,1,0,0,1,1.
REQ-028 SHALL cover: rst_n low for one cycle at frame bit 4 -> next cycle ser_out=0, busy=0, gnt_id=0; subsequent req=0001 produces full new frame.
REQ-029 SHALL cover: ENC_ARB_ID_EN defined, requester 2 sends 1011 -> ser_out 1,0,1,1,1,0,1,0,1,0 (10 cycles).

Source files
------------

// File: rtl/enc_arbiter.sv
// ---------------------------------------------------------------------------
// enc_arbiter
//   Four-way round-robin arbiter feeding a serial Hamming(7,4) frame encoder.
//   A granted requester's nibble is frozen at the grant edge and shifted out
//   as: start(1), [id0, id1], d0, d1, d2, d3, p0, p1, p2.
//
// Parameters
//   IDLE_GAP  : idle cycles (ser_out=0, busy=0) forced between frames, 0..15
//
// Optional feature
//   ENC_ARB_ID_EN : when defined, gnt_id[0] then gnt_id[1] are sent between
//                   the start bit and d0 (10-bit frame instead of 8-bit).
//
// Ports
//   clk       in   1  clock, rising edge
//   rst_n     in   1  synchronous active-low reset
//   req       in   4  request per requester
//   req_data  in  16  nibble of requester i in [4i+3:4i]
//   ack       out  4  one-hot single-cycle capture pulse
//   ser_out   out  1  serial frame line, idle low
//   busy      out  1  high while a frame bit is driven
//   gnt_id    out  2  owner of current/last frame
// ---------------------------------------------------------------------------
module enc_arbiter #(
  parameter int IDLE_GAP = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [15:0] req_data,
  output logic [3:0]  ack,
  output logic        ser_out,
  output logic        busy,
  output logic [1:0]  gnt_id
);

`ifdef ENC_ARB_ID_EN
  localparam int FRAME_LEN = 10;
`else
  localparam int FRAME_LEN = 8;
`endif
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);
  localparam logic [3:0] GAP_LOAD = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                 state_r, state_s;
  logic [3:0]             idx_r, idx_s;      // index of the bit currently on ser_out
  logic [3:0]             gap_r, gap_s;      // remaining gap cycles minus one
  logic [FRAME_LEN-2:0]   sh_r, sh_s;        // bits still to send after the current one
  logic [1:0]             last_r, last_s;    // round-robin pointer
  logic [1:0]             gnt_s;
  logic [3:0]             ack_s;
  logic                   ser_s;
  logic                   busy_s;
  logic                   eval_s;            // this edge may start a new frame
  logic [2:0]             pick_s;            // {valid, index}
  logic [3:0]             nib_s;

  // Hamming(7,4) parity bits, returned as {p2, p1, p0}
  function automatic logic [2:0] hamming_parity(input logic [3:0] d);
    logic [2:0] p;
    p[0] = d[0] ^ d[1] ^ d[2];
    p[1] = d[0] ^ d[1] ^ d[3];
    p[2] = d[0] ^ d[2] ^ d[3];
    return p;
  endfunction

  // Round-robin pick: nearest requester after 'last'. Scanning from the
  // farthest candidate to the nearest lets the nearest one overwrite.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (r[cand]) begin
        res = {1'b1, cand};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    gap_s   = gap_r;
    sh_s    = sh_r;
    last_s  = last_r;
    gnt_s   = gnt_id;
    ack_s   = 4'b0000;
    ser_s   = 1'b0;
    busy_s  = 1'b0;
    eval_s  = 1'b0;
    pick_s  = rr_pick(req, last_r);
    nib_s   = req_data[{pick_s[1:0], 2'b00} +: 4];

    case (state_r)
      IDLE: begin
        eval_s  = 1'b1;
        state_s = IDLE;
      end
      FRAME: begin
        if (idx_r == LAST_IDX) begin
          if (IDLE_GAP == 0) begin
            eval_s  = 1'b1;
            state_s = IDLE;
          end else begin
            state_s = GAP;
            gap_s   = GAP_LOAD;
          end
        end else begin
          idx_s  = idx_r + 4'd1;
          ser_s  = sh_r[0];
          sh_s   = {1'b0, sh_r[FRAME_LEN-2:1]};
          busy_s = 1'b1;
        end
      end
      GAP: begin
        if (gap_r == 4'd0) begin
          eval_s  = 1'b1;
          state_s = IDLE;
        end else begin
          gap_s = gap_r - 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Grant: nibble frozen into the shift register, start bit goes out next
    if (eval_s && pick_s[2]) begin
      state_s = FRAME;
      idx_s   = 4'd0;
      last_s  = pick_s[1:0];
      gnt_s   = pick_s[1:0];
      ack_s   = 4'b0001 << pick_s[1:0];
      ser_s   = 1'b1;
      busy_s  = 1'b1;
`ifdef ENC_ARB_ID_EN
      sh_s    = {hamming_parity(nib_s), nib_s, pick_s[1:0]};
`else
      sh_s    = {hamming_parity(nib_s), nib_s};
`endif
    end else begin
      ack_s = 4'b0000;
    end
  end

  // State and registered outputs; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= 4'd0;
      gap_r   <= 4'd0;
      sh_r    <= {(FRAME_LEN-1){1'b0}};
      last_r  <= 2'd3;
      gnt_id  <= 2'd0;
      ack     <= 4'b0000;
      ser_out <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      gap_r   <= gap_s;
      sh_r    <= sh_s;
      last_r  <= last_s;
      gnt_id  <= gnt_s;
      ack     <= ack_s;
      ser_out <= ser_s;
      busy    <= busy_s;
    end
  end

endmodule

// File: tb/tb_enc_arbiter.sv
// ---------------------------------------------------------------------------
// tb_enc_arbiter
//   Drives two enc_arbiter instances (IDLE_GAP=0 and IDLE_GAP=3) and compares
//   every cycle against a frame-level reference model: at each free grant
//   edge the model picks a requester round-robin and queues the whole
//   expected frame (plus gap cycles) as per-cycle output words.
// ---------------------------------------------------------------------------
module tb_enc_arbiter;

`ifdef ENC_ARB_ID_EN
  localparam int TB_FLEN   = 10;
  localparam bit TB_ID_EN  = 1'b1;
  localparam bit E024 [10] = '{1,0,0,1,1,0,1,0,1,0};
  localparam bit EFRZ [10] = '{1,0,1,0,1,1,0,0,1,1};
  localparam bit EID  [10] = '{1,0,1,1,1,0,1,0,1,0};
`else
  localparam int TB_FLEN   = 8;
  localparam bit TB_ID_EN  = 1'b0;
  localparam bit E024 [10] = '{1,1,1,0,1,0,1,0,0,0};
  localparam bit EFRZ [10] = '{1,0,1,1,0,0,1,1,0,0};
`endif
  localparam int G3 = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req0, req3;
  logic [15:0] req_data;
  logic [3:0]  ack0, ack3;
  logic        ser0, ser3, busy0, busy3;
  logic [1:0]  gnt0, gnt3;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: expected word = {ser, busy, ack[3:0], gnt[1:0]}
  logic [7:0] exp0, exp3;
  logic [7:0] q0[$];
  logic [7:0] q3[$];
  logic [1:0] last0, last3, mg0, mg3;

  enc_arbiter #(.IDLE_GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .req_data(req_data),
    .ack(ack0), .ser_out(ser0), .busy(busy0), .gnt_id(gnt0)
  );

  enc_arbiter #(.IDLE_GAP(G3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .req_data(req_data),
    .ack(ack3), .ser_out(ser3), .busy(busy3), .gnt_id(gnt3)
  );

  always #5 clk = ~clk;

  function automatic int pick_rr(input logic [3:0] r, input logic [1:0] last);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (int'(last) + k) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // Frame bits in transmission order, bit 0 sent first
  function automatic logic [9:0] frame_bits(input logic [3:0] d, input logic [1:0] id);
    logic [9:0] f;
    int n;
    f = 10'd0;
    n = 0;
    f[n] = 1'b1; n++;
    if (TB_ID_EN) begin
      f[n] = id[0]; n++;
      f[n] = id[1]; n++;
    end
    for (int i = 0; i < 4; i++) begin
      f[n] = d[i]; n++;
    end
    f[n] = d[0] ^ d[1] ^ d[2]; n++;
    f[n] = d[0] ^ d[1] ^ d[3]; n++;
    f[n] = d[0] ^ d[2] ^ d[3];
    return f;
  endfunction

  always @(posedge clk) begin : model0
    int p;
    logic [9:0] fb;
    if (!rst_n) begin
      q0.delete();
      last0 = 2'd3;
      mg0   = 2'd0;
      exp0  = 8'h00;
    end else begin
      if (q0.size() == 0) begin
        p = pick_rr(req0, last0);
        if (p >= 0) begin
          last0 = 2'(p);
          mg0   = 2'(p);
          fb    = frame_bits(req_data[p*4 +: 4], mg0);
          for (int k = 0; k < TB_FLEN; k++)
            q0.push_back({fb[k], 1'b1, (k == 0) ? (4'b0001 << p) : 4'b0000, mg0});
        end
      end
      if (q0.size() > 0) exp0 = q0.pop_front();
      else               exp0 = {2'b00, 4'b0000, mg0};
    end
  end

  always @(posedge clk) begin : model3
    int p;
    logic [9:0] fb;
    if (!rst_n) begin
      q3.delete();
      last3 = 2'd3;
      mg3   = 2'd0;
      exp3  = 8'h00;
    end else begin
      if (q3.size() == 0) begin
        p = pick_rr(req3, last3);
        if (p >= 0) begin
          last3 = 2'(p);
          mg3   = 2'(p);
          fb    = frame_bits(req_data[p*4 +: 4], mg3);
          for (int k = 0; k < TB_FLEN; k++)
            q3.push_back({fb[k], 1'b1, (k == 0) ? (4'b0001 << p) : 4'b0000, mg3});
          for (int k = 0; k < G3; k++)
            q3.push_back({2'b00, 4'b0000, mg3});
        end
      end
      if (q3.size() > 0) exp3 = q3.pop_front();
      else               exp3 = {2'b00, 4'b0000, mg3};
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0 = 4'b0; req3 = 4'b0; req_data = 16'h0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ser0, busy0, ack0, gnt0} !== 8'h00) begin
      n_fail++; $display("FAIL reset_dut0 got=%b exp=%b", {ser0, busy0, ack0, gnt0}, 8'h00);
    end
    n_checks++;
    if ({ser3, busy3, ack3, gnt3} !== 8'h00) begin
      n_fail++; $display("FAIL reset_dut3 got=%b exp=%b", {ser3, busy3, ack3, gnt3}, 8'h00);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ser0, busy0, ack0, gnt0} !== 8'h00) begin
      n_fail++; $display("FAIL idle_after_reset got=%b exp=%b", {ser0, busy0, ack0, gnt0}, 8'h00);
    end
  endtask

  task automatic test_single_frame();
    req_data = 16'h000B;
    req0 = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if ({ser0, busy0, ack0, gnt0} !== exp0) begin
        n_fail++; $display("FAIL single_model k=%0d got=%b exp=%b", k, {ser0, busy0, ack0, gnt0}, exp0);
      end
      n_checks++;
      if (ser0 !== E024[k] || busy0 !== (k < TB_FLEN)) begin
        n_fail++; $display("FAIL single_ser k=%0d got=%b/%b exp=%b/%b", k, ser0, busy0, E024[k], (k < TB_FLEN));
      end
      n_checks++;
      if (ack0 !== ((k == 0) ? 4'b0001 : 4'b0000)) begin
        n_fail++; $display("FAIL single_ack k=%0d got=%b", k, ack0);
      end
      if (k == 0) req0 = 4'b0000;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_data = 16'h0000;
    req0 = 4'b1111;
    for (int k = 0; k < 5 * TB_FLEN; k++) begin
      @(negedge clk);
      n_checks++;
      if ({ser0, busy0, ack0, gnt0} !== exp0) begin
        n_fail++; $display("FAIL b2b_model k=%0d got=%b exp=%b", k, {ser0, busy0, ack0, gnt0}, exp0);
      end
      n_checks++;
      if (busy0 !== 1'b1 || gnt0 !== 2'((k / TB_FLEN) % 4)) begin
        n_fail++; $display("FAIL b2b_busy_gnt k=%0d got=%b/%0d exp=1/%0d", k, busy0, gnt0, (k / TB_FLEN) % 4);
      end
      n_checks++;
      if (ack0 !== ((k % TB_FLEN == 0) ? (4'b0001 << ((k / TB_FLEN) % 4)) : 4'b0000)) begin
        n_fail++; $display("FAIL b2b_ack k=%0d got=%b", k, ack0);
      end
    end
    req0 = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (ser0 !== 1'b0 || busy0 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle got=%b/%b exp=0/0", ser0, busy0);
    end
  endtask

  task automatic test_gap();
    do_reset();
    req_data = 16'h0000;
    req3 = 4'b0011;
    for (int k = 0; k < 2 * TB_FLEN + G3 + 4; k++) begin
      logic eb;
      @(negedge clk);
      eb = (k < TB_FLEN) || (k >= TB_FLEN + G3 && k < 2 * TB_FLEN + G3);
      n_checks++;
      if ({ser3, busy3, ack3, gnt3} !== exp3) begin
        n_fail++; $display("FAIL gap_model k=%0d got=%b exp=%b", k, {ser3, busy3, ack3, gnt3}, exp3);
      end
      n_checks++;
      if (busy3 !== eb || (!eb && ser3 !== 1'b0)) begin
        n_fail++; $display("FAIL gap_busy k=%0d got=%b/%b exp_busy=%b", k, ser3, busy3, eb);
      end
      if (k == 0 || k == TB_FLEN + G3) begin
        n_checks++;
        if (ack3 !== ((k == 0) ? 4'b0001 : 4'b0010) || ser3 !== 1'b1) begin
          n_fail++; $display("FAIL gap_grant k=%0d got=%b/%b", k, ack3, ser3);
        end
      end
      if (k == TB_FLEN + G3) req3 = 4'b0000;
    end
  endtask

  task automatic test_data_freeze();
    do_reset();
    req_data = 16'h0600;
    req0 = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if ({ser0, busy0, ack0, gnt0} !== exp0) begin
        n_fail++; $display("FAIL freeze_model k=%0d got=%b exp=%b", k, {ser0, busy0, ack0, gnt0}, exp0);
      end
      n_checks++;
      if (ser0 !== EFRZ[k] || gnt0 !== 2'd2) begin
        n_fail++; $display("FAIL freeze_ser k=%0d got=%b/%0d exp=%b/2", k, ser0, gnt0, EFRZ[k]);
      end
      if (k == 0) req0 = 4'b0000;
      if (k == 2) req_data[11:8] = 4'hF;
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    req_data = 16'h00BB;
    req0 = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if ({ser0, busy0, ack0, gnt0} !== exp0) begin
        n_fail++; $display("FAIL abort_model k=%0d got=%b exp=%b", k, {ser0, busy0, ack0, gnt0}, exp0);
      end
      if (k == 0) req0 = 4'b0000;
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ser0, busy0, ack0, gnt0} !== 8'h00) begin
      n_fail++; $display("FAIL abort_reset got=%b exp=%b", {ser0, busy0, ack0, gnt0}, 8'h00);
    end
    rst_n = 1'b1;
    req0 = 4'b0011;
    for (int k = 0; k <= TB_FLEN; k++) begin
      @(negedge clk);
      n_checks++;
      if ({ser0, busy0, ack0, gnt0} !== exp0) begin
        n_fail++; $display("FAIL restart_model k=%0d got=%b exp=%b", k, {ser0, busy0, ack0, gnt0}, exp0);
      end
      if (k < TB_FLEN) begin
        n_checks++;
        if (ser0 !== E024[k] || busy0 !== 1'b1 || ack0 !== ((k == 0) ? 4'b0001 : 4'b0000)) begin
          n_fail++; $display("FAIL restart_frame k=%0d got=%b/%b/%b exp_ser=%b", k, ser0, busy0, ack0, E024[k]);
        end
      end else begin
        n_checks++;
        if (ack0 !== 4'b0010 || gnt0 !== 2'd1 || ser0 !== 1'b1) begin
          n_fail++; $display("FAIL restart_next got=%b/%0d/%b exp=0010/1/1", ack0, gnt0, ser0);
        end
      end
      if (k == 0) req0[0] = 1'b0;
      if (k == TB_FLEN) req0 = 4'b0000;
    end
    for (int k = 0; k < TB_FLEN + 2; k++) begin
      @(negedge clk);
      n_checks++;
      if ({ser0, busy0, ack0, gnt0} !== exp0) begin
        n_fail++; $display("FAIL restart_drain k=%0d got=%b exp=%b", k, {ser0, busy0, ack0, gnt0}, exp0);
      end
    end
  endtask

`ifdef ENC_ARB_ID_EN
  task automatic test_id_frame();
    do_reset();
    req_data = 16'h0B00;
    req0 = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (ser0 !== EID[k] || busy0 !== 1'b1) begin
        n_fail++; $display("FAIL id_frame k=%0d got=%b/%b exp=%b/1", k, ser0, busy0, EID[k]);
      end
      if (k == 0) req0 = 4'b0000;
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      n_checks++;
      if ({ser0, busy0, ack0, gnt0} !== exp0) begin
        n_fail++; $display("FAIL rand_dut0 c=%0d got=%b exp=%b", c, {ser0, busy0, ack0, gnt0}, exp0);
      end
      n_checks++;
      if ({ser3, busy3, ack3, gnt3} !== exp3) begin
        n_fail++; $display("FAIL rand_dut3 c=%0d got=%b exp=%b", c, {ser3, busy3, ack3, gnt3}, exp3);
      end
      req_data = 16'($urandom);
      rst_n = ($urandom_range(0, 149) != 0);
      for (int i = 0; i < 4; i++) begin
        if (exp0[2+i]) req0[i] = 1'b0;
        else if (!req0[i] && $urandom_range(0, 3) == 0) req0[i] = 1'b1;
        if (exp3[2+i]) req3[i] = 1'b0;
        else if (!req3[i] && $urandom_range(0, 3) == 0) req3[i] = 1'b1;
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gap();
    test_data_freeze();
    test_reset_mid_frame();
`ifdef ENC_ARB_ID_EN
    test_id_frame();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
